// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and types for the butterfly and twiddle stages.
package fft_pkg;

    localparam int LANES_DEF      = 16;
    localparam int WIDTH_DEF      = 12;
    localparam int HALF_BEATS_DEF = 4;

    typedef logic signed [WIDTH_DEF-1:0] lane_vec_t [LANES_DEF];

    function automatic int beat_cnt_w(input int half_beats);
        return (half_beats < 1) ? 1 : $clog2(2 * half_beats);
    endfunction

    localparam int BEAT_CNT_W = beat_cnt_w(HALF_BEATS_DEF);

endpackage

// File: rtl/bfly10_lane.sv
// One complex lane of the radix-2 butterfly: sign-extend both operands one bit, then add and subtract.
module bfly10_lane
    import fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic signed [WIDTH-2:0] i_a_re,
    input  logic signed [WIDTH-2:0] i_a_im,
    input  logic signed [WIDTH-2:0] i_b_re,
    input  logic signed [WIDTH-2:0] i_b_im,
    output logic signed [WIDTH-1:0] o_sum_re,
    output logic signed [WIDTH-1:0] o_sum_im,
    output logic signed [WIDTH-1:0] o_diff_re,
    output logic signed [WIDTH-1:0] o_diff_im
);

    logic signed [WIDTH-1:0] w_a_re;
    logic signed [WIDTH-1:0] w_a_im;
    logic signed [WIDTH-1:0] w_b_re;
    logic signed [WIDTH-1:0] w_b_im;

    assign w_a_re = {i_a_re[WIDTH-2], i_a_re};
    assign w_a_im = {i_a_im[WIDTH-2], i_a_im};
    assign w_b_re = {i_b_re[WIDTH-2], i_b_re};
    assign w_b_im = {i_b_im[WIDTH-2], i_b_im};

    // One extra bit of headroom makes both results exact.
    assign o_sum_re  = w_a_re + w_b_re;
    assign o_sum_im  = w_a_im + w_b_im;
    assign o_diff_re = w_a_re - w_b_re;
    assign o_diff_im = w_a_im - w_b_im;

endmodule

// File: rtl/bfly10_stage.sv
// Radix-2 butterfly stage: buffers the first half-frame, then pairs each second-half beat
// with the beat HALF_BEATS earlier and registers sum/diff blocks for the twiddle stage.
module bfly10_stage
    import fft_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int HALF_BEATS = HALF_BEATS_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            din_valid,
    input  logic signed [WIDTH-2:0]         din_re       [LANES],
    input  logic signed [WIDTH-2:0]         din_im       [LANES],
    output logic                            bfly_valid,
    output logic [$clog2(HALF_BEATS)-1:0]   bfly_blk_idx,
    output logic signed [WIDTH-1:0]         bfly_sum_re  [LANES],
    output logic signed [WIDTH-1:0]         bfly_sum_im  [LANES],
    output logic signed [WIDTH-1:0]         bfly_diff_re [LANES],
    output logic signed [WIDTH-1:0]         bfly_diff_im [LANES]
);

    // state | meaning
    // FILL  | beat_cnt < HALF_BEATS, storing first-half beats into the buffer
    // CALC  | beat_cnt >= HALF_BEATS, emitting one sum/diff block per valid beat
    localparam int CW = beat_cnt_w(HALF_BEATS);
    localparam int IW = $clog2(HALF_BEATS);

    localparam logic STATE_FILL = 1'b0;
    localparam logic STATE_CALC = 1'b1;

    localparam logic [CW-1:0] HALF      = CW'(HALF_BEATS);
    localparam logic [CW-1:0] LAST_FILL = CW'(HALF_BEATS - 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(2 * HALF_BEATS - 1);

    logic [CW-1:0] r_beat_cnt;
    logic          r_state;
    logic [IW-1:0] w_k;
    logic [IW-1:0] w_wr_idx;

    logic signed [WIDTH-2:0] r_buf_re [HALF_BEATS][LANES];
    logic signed [WIDTH-2:0] r_buf_im [HALF_BEATS][LANES];

    logic signed [WIDTH-1:0] w_sum_re  [LANES];
    logic signed [WIDTH-1:0] w_sum_im  [LANES];
    logic signed [WIDTH-1:0] w_diff_re [LANES];
    logic signed [WIDTH-1:0] w_diff_im [LANES];

    assign w_k      = IW'(r_beat_cnt - HALF);
    assign w_wr_idx = IW'(r_beat_cnt);

    // Buffer needs no reset: every slot is rewritten in FILL before CALC reads it.
    always_ff @(posedge clk) begin
        if (din_valid && (r_state == STATE_FILL)) begin
            for (int l = 0; l < LANES; l++) begin
                r_buf_re[w_wr_idx][l] <= din_re[l];
                r_buf_im[w_wr_idx][l] <= din_im[l];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        bfly10_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .i_a_re   (r_buf_re[w_k][g]),
            .i_a_im   (r_buf_im[w_k][g]),
            .i_b_re   (din_re[g]),
            .i_b_im   (din_im[g]),
            .o_sum_re (w_sum_re[g]),
            .o_sum_im (w_sum_im[g]),
            .o_diff_re(w_diff_re[g]),
            .o_diff_im(w_diff_im[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt   <= '0;
            r_state      <= STATE_FILL;
            bfly_valid   <= 1'b0;
            bfly_blk_idx <= '0;
            for (int l = 0; l < LANES; l++) begin
                bfly_sum_re[l]  <= '0;
                bfly_sum_im[l]  <= '0;
                bfly_diff_re[l] <= '0;
                bfly_diff_im[l] <= '0;
            end
        end else begin
            bfly_valid <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    STATE_FILL: begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == LAST_FILL) begin
                            r_state <= STATE_CALC;
                        end
                    end
                    STATE_CALC: begin
                        bfly_valid   <= 1'b1;
                        bfly_blk_idx <= w_k;
                        for (int l = 0; l < LANES; l++) begin
                            bfly_sum_re[l]  <= w_sum_re[l];
                            bfly_sum_im[l]  <= w_sum_im[l];
                            bfly_diff_re[l] <= w_diff_re[l];
                            bfly_diff_im[l] <= w_diff_im[l];
                        end
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_beat_cnt <= '0;
                            r_state    <= STATE_FILL;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_beat_cnt <= '0;
                        r_state    <= STATE_FILL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bfly10_stage.sv
// Self-checking bench for bfly10_stage against a frame-level butterfly reference model.
module tb_bfly10_stage;

    localparam int W  = 12;
    localparam int L  = 16;
    localparam int H  = 4;
    localparam int IW = W - 1;
    localparam int NB = 2 * H;

    typedef logic [L*IW-1:0] beat_t;
    typedef struct packed {
        logic [1:0]     idx;
        logic [L*W-1:0] sre;
        logic [L*W-1:0] sim;
        logic [L*W-1:0] dre;
        logic [L*W-1:0] dim;
    } out_t;

    logic                 clk;
    logic                 rst;
    logic                 din_valid;
    logic signed [IW-1:0] din_re [L];
    logic signed [IW-1:0] din_im [L];
    logic                 bfly_valid;
    logic [1:0]           bfly_blk_idx;
    logic signed [W-1:0]  bfly_sum_re  [L];
    logic signed [W-1:0]  bfly_sum_im  [L];
    logic signed [W-1:0]  bfly_diff_re [L];
    logic signed [W-1:0]  bfly_diff_im [L];

    out_t  cap_q[$];
    out_t  exp_q[$];
    out_t  mon_o;
    beat_t fr_re [NB];
    beat_t fr_im [NB];
    int    n_checks;
    int    n_pass;

    bfly10_stage #(.WIDTH(W), .LANES(L), .HALF_BEATS(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din_re      (din_re),
        .din_im      (din_im),
        .bfly_valid  (bfly_valid),
        .bfly_blk_idx(bfly_blk_idx),
        .bfly_sum_re (bfly_sum_re),
        .bfly_sum_im (bfly_sum_im),
        .bfly_diff_re(bfly_diff_re),
        .bfly_diff_im(bfly_diff_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t cur_out();
        out_t o;
        o.idx = bfly_blk_idx;
        for (int l = 0; l < L; l++) begin
            o.sre[l*W +: W] = bfly_sum_re[l];
            o.sim[l*W +: W] = bfly_sum_im[l];
            o.dre[l*W +: W] = bfly_diff_re[l];
            o.dim[l*W +: W] = bfly_diff_im[l];
        end
        return o;
    endfunction

    always @(negedge clk) begin
        if (bfly_valid === 1'b1) begin
            mon_o = cur_out();
            cap_q.push_back(mon_o);
        end
    end

    // Reference: block k of a frame pairs beat k with beat k+H, exact integer sum/diff.
    function automatic void model_frame();
        out_t e;
        logic signed [IW-1:0] sa;
        int ar, ai, br, bi;
        for (int k = 0; k < H; k++) begin
            e = '0;
            e.idx = 2'(k);
            for (int l = 0; l < L; l++) begin
                sa = fr_re[k][l*IW +: IW];     ar = sa;
                sa = fr_im[k][l*IW +: IW];     ai = sa;
                sa = fr_re[k+H][l*IW +: IW];   br = sa;
                sa = fr_im[k+H][l*IW +: IW];   bi = sa;
                e.sre[l*W +: W] = W'(ar + br);
                e.sim[l*W +: W] = W'(ai + bi);
                e.dre[l*W +: W] = W'(ar - br);
                e.dim[l*W +: W] = W'(ai - bi);
            end
            exp_q.push_back(e);
        end
    endfunction

    function automatic void rand_frame();
        for (int b = 0; b < NB; b++) begin
            for (int l = 0; l < L; l++) begin
                fr_re[b][l*IW +: IW] = IW'($urandom);
                fr_im[b][l*IW +: IW] = IW'($urandom);
            end
        end
    endfunction

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input int b);
        din_valid = 1'b1;
        for (int l = 0; l < L; l++) begin
            din_re[l] = fr_re[b][l*IW +: IW];
            din_im[l] = fr_im[b][l*IW +: IW];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit gaps);
        model_frame();
        for (int b = 0; b < NB; b++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 2));
            drive_beat(b);
        end
    endtask

    task automatic test_reset();
        out_t z;
        z = '0;
        rst = 1'b1;
        idle(2);
        n_checks++;
        if (bfly_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bfly_valid);
        else n_pass++;
        n_checks++;
        if (cur_out() !== z) $display("FAIL reset_data: got %h want %h", cur_out(), z);
        else n_pass++;
        rst = 1'b0;
        idle(1);
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic test_ramp();
        for (int b = 0; b < NB; b++) begin
            fr_re[b] = '0;
            fr_im[b] = '0;
            fr_re[b][IW-1:0] = IW'(b + 1);
        end
        send_frame(1'b0);
        idle(2);
        n_checks++;
        if (cap_q.size() != H) $display("FAIL ramp_count: got %0d want %0d", cap_q.size(), H);
        else n_pass++;
        for (int k = 0; k < H && k < cap_q.size(); k++) begin
            n_checks++;
            if (cap_q[k].idx !== 2'(k)) $display("FAIL ramp_idx%0d: got %0d want %0d", k, cap_q[k].idx, k);
            else n_pass++;
            n_checks++;
            if ($signed(cap_q[k].sre[W-1:0]) !== W'(6 + 2 * k))
                $display("FAIL ramp_sum%0d: got %0d want %0d", k, $signed(cap_q[k].sre[W-1:0]), 6 + 2 * k);
            else n_pass++;
            n_checks++;
            if (cap_q[k].dre[W-1:0] !== 12'hFFC)
                $display("FAIL ramp_diff%0d: got %0d want -4", k, $signed(cap_q[k].dre[W-1:0]));
            else n_pass++;
            n_checks++;
            if (cap_q[k].sim !== '0) $display("FAIL ramp_im%0d: got %h want 0", k, cap_q[k].sim);
            else n_pass++;
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic test_extremes();
        for (int b = 0; b < NB; b++) begin
            fr_re[b] = {L{11'h400}};
            fr_im[b] = {L{11'h400}};
        end
        send_frame(1'b0);
        for (int b = 0; b < NB; b++) begin
            fr_re[b] = (b < H) ? {L{11'h3FF}} : {L{11'h400}};
            fr_im[b] = fr_re[b];
        end
        send_frame(1'b0);
        idle(2);
        n_checks++;
        if (cap_q.size() != 2 * H) $display("FAIL ext_count: got %0d want %0d", cap_q.size(), 2 * H);
        else n_pass++;
        for (int i = 0; i < 2 * H && i < cap_q.size(); i++) begin
            n_checks++;
            if (i < H) begin
                if (cap_q[i].sre !== {L{12'h800}} || cap_q[i].sim !== {L{12'h800}} ||
                    cap_q[i].dre !== '0 || cap_q[i].dim !== '0)
                    $display("FAIL ext_neg%0d: got sum %h diff %h want sum -2048 diff 0",
                             i, cap_q[i].sre[W-1:0], cap_q[i].dre[W-1:0]);
                else n_pass++;
            end else begin
                if (cap_q[i].sre !== {L{12'hFFF}} || cap_q[i].sim !== {L{12'hFFF}} ||
                    cap_q[i].dre !== {L{12'h7FF}} || cap_q[i].dim !== {L{12'h7FF}})
                    $display("FAIL ext_mix%0d: got sum %h diff %h want sum -1 diff 2047",
                             i, cap_q[i].sre[W-1:0], cap_q[i].dre[W-1:0]);
                else n_pass++;
            end
            n_checks++;
            if (i < exp_q.size() && cap_q[i] !== exp_q[i]) $display("FAIL ext_model%0d: got %h want %h", i, cap_q[i].sre, exp_q[i].sre);
            else n_pass++;
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stream(input bit gaps, input int nframes);
        for (int f = 0; f < nframes; f++) begin
            rand_frame();
            send_frame(gaps);
        end
        idle(2);
        n_checks++;
        if (cap_q.size() != exp_q.size())
            $display("FAIL stream_count(gaps=%0b): got %0d want %0d", gaps, cap_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i])
                $display("FAIL stream%0d(gaps=%0b): got idx %0d sum %h want idx %0d sum %h",
                         i, gaps, cap_q[i].idx, cap_q[i].sre, exp_q[i].idx, exp_q[i].sre);
            else n_pass++;
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        test_stream(1'b0, 3);
    endtask

    task automatic test_gaps();
        test_stream(1'b1, 2);
    endtask

    task automatic test_reset_mid();
        rand_frame();
        for (int b = 0; b < 6; b++) drive_beat(b);
        din_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (bfly_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", bfly_valid);
        else n_pass++;
        cap_q.delete();
        exp_q.delete();
        idle(1);
        test_stream(1'b0, 1);
    endtask

    task automatic test_hold();
        out_t last;
        rand_frame();
        send_frame(1'b0);
        last = exp_q[H-1];
        for (int c = 0; c < 5; c++) begin
            idle(1);
            n_checks++;
            if (bfly_valid !== 1'b0 || cur_out() !== last)
                $display("FAIL hold%0d: got valid %b data %h want valid 0 data %h", c, bfly_valid, cur_out(), last);
            else n_pass++;
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        din_valid = 1'b0;
        for (int l = 0; l < L; l++) begin
            din_re[l] = '0;
            din_im[l] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_ramp();
        test_extremes();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_hold();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
